// File: rtl/rtc_bus_pkg.sv
// Shared types and helpers for the RTC date writer: FSM state encoding,
// default RTC register addresses and packed-BCD date helpers.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_PHASE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam logic [7:0] RTC_ADDR_DIA  = 8'h24;
   localparam logic [7:0] RTC_ADDR_MES  = 8'h25;
   localparam logic [7:0] RTC_ADDR_YEAR = 8'h26;

   // True when both nibbles of a packed-BCD byte are decimal digits.
   function automatic logic bcd_valid(input logic [7:0] b);
      logic ok;
      ok = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
      return ok;
   endfunction

   // Last valid day (packed BCD) for a packed-BCD month; February is fixed
   // at 29 since the year is not examined.
   function automatic logic [7:0] days_in_month(input logic [7:0] m);
      logic [7:0] lim;
      case (m)
         8'h02:                      lim = 8'h29;
         8'h04, 8'h06, 8'h09, 8'h11: lim = 8'h30;
         default:                    lim = 8'h31;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter used to time both the strobe-low phase and the
// strobe-high gap. load wins over counting; expired is high while the
// count sits at zero.
module rtc_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: reload on request, otherwise decrement and stick at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_date_writer.sv
// Writes a committed day/month/year (packed BCD) into three RTC registers
// over a multiplexed address/data bus. Each register gets an address phase
// then a data phase; every phase holds wr_n low for PHASE_CYCLES and then
// high for GAP_CYCLES.
// Optional: define RTC_DATE_WRITER_DATE_CHECK_EN to validate the date in
// LATCH and pulse error (no bus activity) on an impossible date.
//
// Handshake: start is a request sampled only in IDLE; the date inputs are
// snapshotted on that cycle. busy covers LATCH through the last gap, done
// is a one-cycle completion pulse (FINISH), error a one-cycle reject pulse.
module rtc_date_writer
   import rtc_bus_pkg::*;
#(
   parameter int         PHASE_CYCLES = 10,
   parameter int         GAP_CYCLES   = 4,
   parameter logic [7:0] ADDR_DIA     = RTC_ADDR_DIA,
   parameter logic [7:0] ADDR_MES     = RTC_ADDR_MES,
   parameter logic [7:0] ADDR_YEAR    = RTC_ADDR_YEAR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] dia,
   input  logic [7:0] mes,
   input  logic [7:0] year,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       ad_sel,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output state_e     state_dbg
);

   localparam int MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic       ad_sel_q, ad_sel_d;
   logic [7:0] dia_q, dia_d;
   logic [7:0] mes_q, mes_d;
   logic [7:0] year_q, year_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_expired;

   logic       on_bus;
   logic [7:0] cur_addr;
   logic [7:0] cur_data;

`ifdef RTC_DATE_WRITER_DATE_CHECK_EN
   logic error_q, error_d;
   logic date_ok;

   assign date_ok = bcd_valid(dia_q) && bcd_valid(mes_q) && bcd_valid(year_q) &&
                    (mes_q >= 8'h01) && (mes_q <= 8'h12) &&
                    (dia_q != 8'h00) && (dia_q <= days_in_month(mes_q));
`endif

   rtc_phase_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

   // Next-state, register index, address/data select and snapshot logic.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ad_sel_d  = ad_sel_q;
      dia_d     = dia_q;
      mes_d     = mes_q;
      year_d    = year_q;
      tmr_load  = 1'b0;
      tmr_value = PHASE_LOAD;
`ifdef RTC_DATE_WRITER_DATE_CHECK_EN
      error_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dia_d   = dia;
               mes_d   = mes;
               year_d  = year;
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            idx_d    = 2'd0;
            ad_sel_d = 1'b0;
`ifdef RTC_DATE_WRITER_DATE_CHECK_EN
            if (!date_ok) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmr_load  = 1'b1;
               tmr_value = PHASE_LOAD;
               state_d   = ST_PHASE;
            end
`else
            tmr_load  = 1'b1;
            tmr_value = PHASE_LOAD;
            state_d   = ST_PHASE;
`endif
         end
         ST_PHASE: begin
            if (tmr_expired) begin
               tmr_load  = 1'b1;
               tmr_value = GAP_LOAD;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tmr_expired) begin
               if (!ad_sel_q) begin
                  ad_sel_d  = 1'b1;
                  tmr_load  = 1'b1;
                  tmr_value = PHASE_LOAD;
                  state_d   = ST_PHASE;
               end else if (idx_q < 2'd2) begin
                  idx_d     = idx_q + 2'd1;
                  ad_sel_d  = 1'b0;
                  tmr_load  = 1'b1;
                  tmr_value = PHASE_LOAD;
                  state_d   = ST_PHASE;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            idx_d    = 2'd0;
            ad_sel_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, index and snapshot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         ad_sel_q <= 1'b0;
         dia_q    <= 8'h00;
         mes_q    <= 8'h00;
         year_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ad_sel_q <= ad_sel_d;
         dia_q    <= dia_d;
         mes_q    <= mes_d;
         year_q   <= year_d;
      end
   end

`ifdef RTC_DATE_WRITER_DATE_CHECK_EN
   // Reject pulse lands in the IDLE cycle right after LATCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   // Address and data byte for the register currently being written.
   always_comb begin
      cur_addr = ADDR_DIA;
      cur_data = dia_q;
      case (idx_q)
         2'd1: begin
            cur_addr = ADDR_MES;
            cur_data = mes_q;
         end
         2'd2: begin
            cur_addr = ADDR_YEAR;
            cur_data = year_q;
         end
         default: begin
            cur_addr = ADDR_DIA;
            cur_data = dia_q;
         end
      endcase
   end

   // Bus outputs decode straight from registered state, so bus_out only
   // moves when idx/ad_sel change on a GAP->PHASE transition.
   assign on_bus    = (state_q == ST_PHASE) || (state_q == ST_GAP);
   assign busy      = (state_q == ST_LATCH) || on_bus;
   assign done      = (state_q == ST_FINISH);
   assign cs_n      = ~on_bus;
   assign bus_oe    = on_bus;
   assign wr_n      = ~(state_q == ST_PHASE);
   assign rd_n      = 1'b1;
   assign ad_sel    = ad_sel_q;
   assign bus_out   = on_bus ? (ad_sel_q ? cur_data : cur_addr) : 8'h00;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_rtc_date_writer.sv
// Directed bench for rtc_date_writer: a default-timing instance and a
// PHASE_CYCLES=1/GAP_CYCLES=1 instance. Outputs are sampled on the falling
// edge; inputs change on the falling edge.
module tb_rtc_date_writer;
   import rtc_bus_pkg::*;

   localparam int P        = 10;
   localparam int G        = 4;
   localparam int BUSY_EXP = 1 + 6 * (P + G);
   localparam int F_BUSY   = 1 + 6 * (1 + 1);

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] dia, mes, year;
   logic       busy, done, error, cs_n, wr_n, rd_n, ad_sel, bus_oe;
   logic [7:0] bus_out;
   state_e     state_dbg;

   logic       f_start;
   logic [7:0] f_dia, f_mes, f_year;
   logic       f_busy, f_done, f_error, f_cs_n, f_wr_n, f_rd_n, f_ad_sel, f_bus_oe;
   logic [7:0] f_bus_out;
   state_e     f_state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   rtc_date_writer u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dia       (dia),
      .mes       (mes),
      .year      (year),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .cs_n      (cs_n),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .ad_sel    (ad_sel),
      .bus_out   (bus_out),
      .bus_oe    (bus_oe),
      .state_dbg (state_dbg)
   );

   rtc_date_writer #(
      .PHASE_CYCLES (1),
      .GAP_CYCLES   (1)
   ) u_fast (
      .clk       (clk),
      .reset     (reset),
      .start     (f_start),
      .dia       (f_dia),
      .mes       (f_mes),
      .year      (f_year),
      .busy      (f_busy),
      .done      (f_done),
      .error     (f_error),
      .cs_n      (f_cs_n),
      .wr_n      (f_wr_n),
      .rd_n      (f_rd_n),
      .ad_sel    (f_ad_sel),
      .bus_out   (f_bus_out),
      .bus_oe    (f_bus_oe),
      .state_dbg (f_state_dbg)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full default-timing write; inputs are scrambled one cycle after start,
   // and an extra start is pulsed at cycle inject_cyc (0 = none).
   task automatic run_seq(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y,
                          input int inject_cyc, input string tag);
      logic [8:0] exp_q[$];
      int busy_cnt = 0, done_cnt = 0, done_cyc = 0, low_run = 0, high_run = 0, phases = 0;
      int bad_hold = 0, bad_cs = 0, bad_err = 0;
      logic prev_wr = 1'b1;
      logic prev_busy = 1'b0;
      logic [7:0] held = 8'h00;
      exp_q.push_back({1'b0, 8'h24});
      exp_q.push_back({1'b1, d});
      exp_q.push_back({1'b0, 8'h25});
      exp_q.push_back({1'b1, m});
      exp_q.push_back({1'b0, 8'h26});
      exp_q.push_back({1'b1, y});
      @(negedge clk);
      dia = d; mes = m; year = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; dia = 8'h99; mes = 8'h99; year = 8'h99;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (busy) busy_cnt++;
         if (error) bad_err++;
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_cyc = cyc;
               check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end
         end
         if (!wr_n) begin
            if (cs_n || !bus_oe) bad_cs++;
            if (prev_wr) begin
               if (phases > 0) check({tag, "_gap_len"}, high_run, G);
               if (exp_q.size() == 0) check({tag, "_extra_phase"}, 32'd1, 32'd0);
               else check({tag, "_phase_val"}, 32'({ad_sel, bus_out}), 32'(exp_q.pop_front()));
               phases++;
               low_run = 0;
               held = bus_out;
            end
            if (bus_out !== held) bad_hold++;
            low_run++;
         end else begin
            if (!prev_wr) begin
               check({tag, "_low_len"}, low_run, P);
               high_run = 0;
            end
            if (busy) high_run++;
            if (prev_busy && !busy && phases > 0) check({tag, "_last_gap_len"}, high_run, G);
         end
         prev_wr = wr_n;
         prev_busy = busy;
         if (cyc == inject_cyc) begin
            start = 1'b1; dia = 8'h01; mes = 8'h01; year = 8'h01;
         end else begin
            start = 1'b0;
         end
         if (done_cnt > 0 && cyc >= done_cyc + 20) break;
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_busy_cycles"}, busy_cnt, BUSY_EXP);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_done_cycle"}, done_cyc, BUSY_EXP + 1);
      check({tag, "_phase_count"}, phases, 6);
      check({tag, "_hold_while_low"}, bad_hold, 0);
      check({tag, "_cs_oe_while_low"}, bad_cs, 0);
      check({tag, "_no_error"}, bad_err, 0);
   endtask

   // Reset during the month data phase.
   task automatic run_reset_mid;
      int done_cnt = 0, busy_cnt = 0;
      @(negedge clk);
      dia = 8'h15; mes = 8'h07; year = 8'h16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 46; c++) @(negedge clk);
      check("rst_pre_state", 32'({wr_n, ad_sel, bus_out}), 32'({1'b0, 1'b1, 8'h07}));
      reset = 1'b1;
      @(negedge clk);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_wr_n", 32'(wr_n), 32'd1);
      check("rst_bus_oe", 32'(bus_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bus_out", 32'(bus_out), 32'd0);
      reset = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (busy) busy_cnt++;
      end
      check("rst_no_done_after", done_cnt, 0);
      check("rst_stays_idle", busy_cnt, 0);
   endtask

   // One-cycle phase/gap instance.
   task automatic run_fast;
      logic [7:0] exp_q[$];
      int busy_cnt = 0, done_cnt = 0, done_cyc = 0, bad_alt = 0, phases = 0;
      logic prev_wr = 1'b1;
      exp_q = '{8'h24, 8'h31, 8'h25, 8'h12, 8'h26, 8'h99};
      @(negedge clk);
      f_dia = 8'h31; f_mes = 8'h12; f_year = 8'h99; f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (f_busy) begin
            busy_cnt++;
            if (cyc >= 2 && f_wr_n !== ((cyc % 2) == 1)) bad_alt++;
         end
         if (f_done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
         end
         if (!f_wr_n && prev_wr) begin
            if (exp_q.size() == 0) check("fast_extra_phase", 32'd1, 32'd0);
            else check("fast_phase_val", 32'(f_bus_out), 32'(exp_q.pop_front()));
            phases++;
         end
         prev_wr = f_wr_n;
         @(negedge clk);
      end
      check("fast_busy_cycles", busy_cnt, F_BUSY);
      check("fast_done_count", done_cnt, 1);
      check("fast_done_cycle", done_cyc, F_BUSY + 1);
      check("fast_wr_alternates", bad_alt, 0);
      check("fast_phase_count", phases, 6);
   endtask

`ifdef RTC_DATE_WRITER_DATE_CHECK_EN
   // Impossible date: error pulse, no bus activity, no done.
   task automatic run_reject(input logic [7:0] d, input logic [7:0] m, input string tag);
      int err_cnt = 0, err_cyc = 0, busy_cnt = 0, cs_cnt = 0, done_cnt = 0;
      @(negedge clk);
      dia = d; mes = m; year = 8'h16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (error) begin
            err_cnt++;
            err_cyc = cyc;
            check({tag, "_busy_at_error"}, 32'(busy), 32'd0);
         end
         if (busy) busy_cnt++;
         if (!cs_n) cs_cnt++;
         if (done) done_cnt++;
         @(negedge clk);
      end
      check({tag, "_error_count"}, err_cnt, 1);
      check({tag, "_error_cycle"}, err_cyc, 2);
      check({tag, "_busy_cycles"}, busy_cnt, 1);
      check({tag, "_cs_low_cycles"}, cs_cnt, 0);
      check({tag, "_done_count"}, done_cnt, 0);
   endtask
`endif

   // Main sequence.
   initial begin
      reset = 1'b1;
      start = 1'b0; dia = 8'h00; mes = 8'h00; year = 8'h00;
      f_start = 1'b0; f_dia = 8'h00; f_mes = 8'h00; f_year = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_error", 32'(error), 32'd0);
      check("reset_strobes", 32'({cs_n, wr_n, rd_n}), 32'h7);
      check("reset_ad_sel", 32'(ad_sel), 32'd0);
      check("reset_bus", 32'({bus_oe, bus_out}), 32'd0);
      check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
      check("reset_fast_busy", 32'(f_busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_seq(8'h15, 8'h07, 8'h16, 0, "basic");
      run_seq(8'h28, 8'h11, 8'h05, 30, "second_start");
      run_seq(8'h15, 8'h07, 8'h16, 0, "back_again");
      run_reset_mid();
      run_fast();
`ifdef RTC_DATE_WRITER_DATE_CHECK_EN
      run_reject(8'h31, 8'h04, "rej_apr31");
      run_reject(8'h1a, 8'h05, "rej_nibble");
      run_reject(8'h10, 8'h13, "rej_month13");
      run_reject(8'h00, 8'h01, "rej_day0");
      run_seq(8'h29, 8'h02, 8'h16, 0, "feb29");
`else
      run_seq(8'h31, 8'h04, 8'h16, 0, "unchecked_apr31");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
